// File: rtl/jtframe_ram_arb.sv
// Round-robin arbiter sharing one SDRAM bank port between NREQ requesters.
// A granted requester owns the bank until its transfer completes or the
// watchdog expires; read data returns on the shared rq_dout bus.
module jtframe_ram_arb #(
    parameter int unsigned SDRAMW = 22,
    parameter int unsigned DW     = 16,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned TOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        rq_req,
    input  logic [NREQ-1:0]        rq_rnw,
    input  logic [NREQ*SDRAMW-1:0] rq_addr,
    input  logic [NREQ*DW-1:0]     rq_din,
    output logic [NREQ-1:0]        rq_dok,
    output logic [31:0]            rq_dout,
    output logic [NREQ-1:0]        rq_err,
    output logic                   ba_req,
    output logic                   ba_rnw,
    output logic [SDRAMW-1:0]      ba_addr,
    output logic [DW-1:0]          ba_din,
    input  logic                   ba_ack,
    input  logic                   ba_dok,
    input  logic [31:0]            ba_dout,
    output logic                   busy
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            st, st_nxt;
    logic [GW-1:0]     gnt, gnt_nxt;
    logic [GW-1:0]     ptr, ptr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              tmo, tmo_nxt;
    logic [NREQ-1:0]   rq_dok_nxt, rq_err_nxt;
    logic [31:0]       rq_dout_nxt;
    logic              ba_req_nxt, ba_rnw_nxt, busy_nxt;
    logic [SDRAMW-1:0] ba_addr_nxt;
    logic [DW-1:0]     ba_din_nxt;

    logic [GW-1:0]     cand, win;
    logic              found;
    logic [CW-1:0]     cnt_inc;
    logic              expired;

    // Rotating search: first pending request at or after ptr
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = GW'((32'(ptr) + k) % NREQ);
            if (!found && rq_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign cnt_inc = cnt + CW'(1);
    assign expired = (cnt_inc >= CW'(TOUT));

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= IDLE;
            gnt     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            tmo     <= 1'b0;
            rq_dok  <= '0;
            rq_err  <= '0;
            rq_dout <= '0;
            ba_req  <= 1'b0;
            ba_rnw  <= 1'b0;
            ba_addr <= '0;
            ba_din  <= '0;
            busy    <= 1'b0;
        end else begin
            st      <= st_nxt;
            gnt     <= gnt_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
            rq_dok  <= rq_dok_nxt;
            rq_err  <= rq_err_nxt;
            rq_dout <= rq_dout_nxt;
            ba_req  <= ba_req_nxt;
            ba_rnw  <= ba_rnw_nxt;
            ba_addr <= ba_addr_nxt;
            ba_din  <= ba_din_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        st_nxt      = st;
        gnt_nxt     = gnt;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        tmo_nxt     = tmo;
        rq_dok_nxt  = '0;
        rq_err_nxt  = '0;
        rq_dout_nxt = rq_dout;
        ba_req_nxt  = ba_req;
        ba_rnw_nxt  = ba_rnw;
        ba_addr_nxt = ba_addr;
        ba_din_nxt  = ba_din;

        case (st)
            IDLE: begin
                if (found) begin
                    gnt_nxt     = win;
                    ba_req_nxt  = 1'b1;
                    ba_rnw_nxt  = rq_rnw[win];
                    ba_addr_nxt = rq_addr[win*SDRAMW +: SDRAMW];
                    ba_din_nxt  = rq_din[win*DW +: DW];
                    cnt_nxt     = '0;
                    tmo_nxt     = 1'b0;
                    st_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt = cnt_inc;
                // completion beats the watchdog; the watchdog beats a bare ack
                if (ba_ack && ba_dok) begin
                    ba_req_nxt = 1'b0;
                    if (ba_rnw) rq_dout_nxt = ba_dout;
                    st_nxt = DONE;
                end else if (expired) begin
                    ba_req_nxt = 1'b0;
                    tmo_nxt    = 1'b1;
                    st_nxt     = DONE;
                end else if (ba_ack) begin
                    ba_req_nxt = 1'b0;
                    st_nxt     = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt_inc;
                if (ba_dok) begin
                    if (ba_rnw) rq_dout_nxt = ba_dout;
                    st_nxt = DONE;
                end else if (expired) begin
                    tmo_nxt = 1'b1;
                    st_nxt  = DONE;
                end
            end
            DONE: begin
                rq_dok_nxt[gnt] = 1'b1;
                rq_err_nxt[gnt] = tmo;
                ptr_nxt = (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
                st_nxt  = IDLE;
            end
            default: st_nxt = IDLE;
        endcase

        busy_nxt = (st_nxt != IDLE);
    end

endmodule

// File: tb/tb_jtframe_ram_arb.sv
// Randomized bench for jtframe_ram_arb with a transaction-level reference.
module tb_jtframe_ram_arb;

    localparam int unsigned SDRAMW = 22;
    localparam int unsigned DW     = 16;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned TOUT   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        rq_req, rq_rnw, rq_dok, rq_err;
    logic [NREQ*SDRAMW-1:0] rq_addr;
    logic [NREQ*DW-1:0]     rq_din;
    logic [31:0]            rq_dout, ba_dout;
    logic                   ba_req, ba_rnw, ba_ack, ba_dok, busy;
    logic [SDRAMW-1:0]      ba_addr;
    logic [DW-1:0]          ba_din;

    always #5 clk = ~clk;

    jtframe_ram_arb #(
        .SDRAMW(SDRAMW), .DW(DW), .NREQ(NREQ), .TOUT(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_req(rq_req), .rq_rnw(rq_rnw), .rq_addr(rq_addr), .rq_din(rq_din),
        .rq_dok(rq_dok), .rq_dout(rq_dout), .rq_err(rq_err),
        .ba_req(ba_req), .ba_rnw(ba_rnw), .ba_addr(ba_addr), .ba_din(ba_din),
        .ba_ack(ba_ack), .ba_dok(ba_dok), .ba_dout(ba_dout), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: outstanding requests and what the arbiter should remember
    bit                pend   [NREQ];
    logic              rnw_m  [NREQ];
    logic [SDRAMW-1:0] addr_m [NREQ];
    logic [DW-1:0]     din_m  [NREQ];
    int                ptr_m;
    logic [31:0]       dout_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            rq_req[i]                   = pend[i];
            rq_rnw[i]                   = rnw_m[i];
            rq_addr[i*SDRAMW +: SDRAMW] = addr_m[i];
            rq_din[i*DW +: DW]          = din_m[i];
        end
    endtask

    task automatic set_req(input int i, input logic rnw, input logic [SDRAMW-1:0] addr,
                           input logic [DW-1:0] din);
        pend[i]   = 1'b1;
        rnw_m[i]  = rnw;
        addr_m[i] = addr;
        din_m[i]  = din;
    endtask

    // Round-robin choice: first outstanding requester at or after ptr_m
    function automatic int rr_pick();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_ba_req"},  64'(ba_req),  64'(0));
        chk({tag, "_busy"},    64'(busy),    64'(0));
        chk({tag, "_rq_dok"},  64'(rq_dok),  64'(0));
        chk({tag, "_rq_err"},  64'(rq_err),  64'(0));
        chk({tag, "_rq_dout"}, 64'(rq_dout), 64'(0));
        chk({tag, "_ba_addr"}, 64'(ba_addr), 64'(0));
        chk({tag, "_ba_din"},  64'(ba_din),  64'(0));
        chk({tag, "_ba_rnw"},  64'(ba_rnw),  64'(0));
    endtask

    // One transaction starting from an IDLE negedge. The controller acks after
    // 'a' idle ISSUE cycles and completes 'd' cycles after that (d=0: same cycle).
    // Completion is expected a+d+1 edges after the grant unless that exceeds TOUT.
    task automatic do_txn(input int a, input int d, input logic [31:0] bdout, input bit drop);
        int g, done_e, req_end;
        bit to;
        logic [NREQ-1:0] onehot;
        g = rr_pick();
        drive_req();
        ba_ack = 1'b0;
        ba_dok = 1'b0;
        if (g < 0) begin
            @(posedge clk); @(negedge clk);
            chk("idle_ba_req", 64'(ba_req), 64'(0));
            chk("idle_busy",   64'(busy),   64'(0));
            return;
        end
        to      = (a + d + 1 > int'(TOUT));
        done_e  = to ? int'(TOUT) : a + d + 1;
        req_end = (a + 1 < int'(TOUT)) ? a + 1 : int'(TOUT);
        @(posedge clk); @(negedge clk);
        chk("grant_addr", 64'(ba_addr), 64'(addr_m[g]));
        chk("grant_rnw",  64'(ba_rnw),  64'(rnw_m[g]));
        chk("grant_din",  64'(ba_din),  64'(din_m[g]));
        for (int n = 0; n <= done_e + 1; n++) begin
            onehot = (n == done_e + 1) ? (NREQ'(1) << g) : '0;
            chk("ba_req",   64'(ba_req),  64'(n < req_end));
            chk("busy",     64'(busy),    64'(n <= done_e));
            chk("addr_hold",64'(ba_addr), 64'(addr_m[g]));
            chk("rq_dok",   64'(rq_dok),  64'(onehot));
            chk("rq_err",   64'(rq_err),  64'(to ? onehot : '0));
            if (n == done_e + 1) begin
                if (!to && rnw_m[g]) dout_m = bdout;
                chk("rq_dout", 64'(rq_dout), 64'(dout_m));
                pend[g] = 1'b0;
                ptr_m   = (g + 1) % NREQ;
                ba_ack  = 1'b0;
                ba_dok  = 1'b0;
                drive_req();
            end else begin
                ba_ack  = (n == a);
                ba_dok  = !to && (n == a + d);
                ba_dout = (n == a + d) ? bdout : $urandom();
                if (drop && n == 0) begin
                    pend[g] = 1'b0;
                    drive_req();
                end
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    initial begin
        int a, d;
        rst_n = 1'b0;
        ba_ack = 1'b0; ba_dok = 1'b0; ba_dout = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; rnw_m[i] = 1'b0; addr_m[i] = '0; din_m[i] = '0;
        end
        ptr_m = 0;
        dout_m = '0;
        drive_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // single read on requester 1
        set_req(1, 1'b1, 22'h01234, 16'h0000);
        do_txn(2, 3, 32'hCAFE_BEEF, 1'b0);
        chk("read_dout", 64'(rq_dout), 64'h0000_0000_CAFE_BEEF);

        // single write on requester 3; rq_dout must keep the read data
        set_req(3, 1'b0, 22'h2A5A5, 16'hA55A);
        do_txn(1, 1, 32'h1111_2222, 1'b0);
        chk("write_keeps_dout", 64'(rq_dout), 64'h0000_0000_CAFE_BEEF);

        // all four held, 1-cycle controller: order 0,1,2,3,0
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'($urandom_range(0, 1)), SDRAMW'($urandom()), DW'($urandom()));
        for (int t = 0; t < 5; t++) begin
            do_txn(0, 0, $urandom(), 1'b0);
            for (int i = 0; i < NREQ; i++) if (!pend[i]) pend[i] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // watchdog: controller never acks
        set_req(2, 1'b1, SDRAMW'($urandom()), DW'($urandom()));
        do_txn(1000, 0, $urandom(), 1'b0);

        // ack with late completion still times out on the last watchdog cycle
        set_req(0, 1'b1, SDRAMW'($urandom()), DW'($urandom()));
        do_txn(int'(TOUT) - 1, 2, $urandom(), 1'b0);

        // randomized traffic
        repeat (150) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), SDRAMW'($urandom()), DW'($urandom()));
            a = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 6));
            d = int'($urandom_range(0, 3));
            do_txn(a, d, $urandom(), $urandom_range(0, 7) == 0);
        end

        // reset while WAITing, then a stray ba_dok after release
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        set_req(2, 1'b1, SDRAMW'($urandom()), DW'($urandom()));
        drive_req();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_ba_req", 64'(ba_req), 64'(1));
        ba_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        ba_ack = 1'b0;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        pend[2] = 1'b0;
        drive_req();
        ba_dok = 1'b1;
        ba_dout = $urandom();
        @(posedge clk); @(negedge clk);
        ba_dok = 1'b0;
        check_cleared("midrst");
        @(posedge clk); @(negedge clk);
        check_cleared("midrst_late");
        ptr_m = 0;
        dout_m = '0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, SDRAMW'($urandom()), DW'($urandom()));
        do_txn(0, 1, 32'h5A5A_0F0F, 1'b0);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive_req();
        @(posedge clk); @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_ram_arb.md
Name: jtframe_ram_arb

Overview:
- Round-robin arbiter that shares one SDRAM bank port between NREQ read/write requesters.
- Each requester is a request/offset block that raises a level request with a full SDRAM address.
- The arbiter grants one requester at a time, drives the bank port, waits for completion and routes read data back.
- Sits between the per-device request blocks and the SDRAM controller, inside the game's memory-mapping layer.

Parameters:
SDRAMW, 22, SDRAM word address width
DW, 16, write-data width per requester (bits)
NREQ, 4, number of requesters (2..8)
TOUT, 255, watchdog limit in clk cycles for one transfer (1..1023)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
rq_req  in  NREQ  level request per requester, held until its rq_dok pulse
rq_rnw  in  NREQ  1=read, 0=write, valid while rq_req high
rq_addr  in  NREQ*SDRAMW  packed addresses, requester i at [i*SDRAMW +: SDRAMW]
rq_din  in  NREQ*DW  packed write data
rq_dok  out  NREQ  one-cycle completion strobe per requester
rq_dout  out  32  read data, shared by all requesters, valid when any rq_dok bit is high
rq_err  out  NREQ  one-cycle watchdog strobe, coincident with rq_dok
ba_req  out  1  bank request to SDRAM controller
ba_rnw  out  1  bank direction
ba_addr  out  SDRAMW  bank address
ba_din  out  DW  bank write data
ba_ack  in  1  controller accepted command (1-cycle)
ba_dok  in  1  read data valid / write done (1-cycle)
ba_dout  in  32  controller read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset while rst_n=0 at a clock edge:
  - all outputs go to 0, ba_addr/ba_din to 0, state=IDLE.
  - Priority pointer ptr=0, watchdog cnt=0.
  - A transfer in flight is abandoned; late ba_ack/ba_dok after reset are ignored in IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Search rq_req starting at index ptr, wrapping modulo NREQ; the first set bit wins as gnt.
  - If none is set, remain in IDLE.
  - On a win, on the same edge: latch gnt, ba_addr, ba_din and ba_rnw from requester gnt; set ba_req=1; go to ISSUE; clear cnt.
- ISSUE:
  - ba_req stays 1 and the address/data stay stable.
  - On ba_ack: ba_req=0, go to WAIT.
  - If ba_ack and ba_dok arrive in the same cycle: ba_req=0 and take the DONE path directly, skipping WAIT.
- WAIT: on ba_dok, capture ba_dout into rq_dout (reads only; rq_dout keeps its value on writes) and go to DONE.
- DONE, one cycle:
  - rq_dok[gnt]=1.
  - ptr=(gnt+1) mod NREQ.
  - Go to IDLE.
- Latency:
  - An IDLE request produces ba_req on the next edge.
  - rq_dok rises on the edge after the ba_dok edge.
  - Minimum request-to-dok time is 3 cycles when ba_ack and ba_dok coincide on the first cycle.
- Watchdog:
  - cnt increments in ISSUE and WAIT.
  - When cnt reaches TOUT: ba_req=0, rq_dout unchanged, go to DONE with rq_err[gnt]=1 together with rq_dok[gnt]=1.
- Grant behaviour:
  - gnt is fixed for the whole transaction; a requester dropping rq_req mid-transfer does not abort it, and its rq_dok is still pulsed.
  - A requester still holding rq_req in the cycle after its rq_dok is treated as a new request, subject to round-robin.
  - Starvation bound: with all requests held, each requester is served within NREQ transactions.
- Output rules:
  - rq_dok and rq_err are one-hot or zero, never wider than one cycle.
  - ba_rnw, ba_addr and ba_din are held after ba_req falls until the next grant.

Test Plan:
- Single read: rq_req[1]=1, rq_rnw[1]=1, rq_addr[1]=22'h01234; ack after 2 cycles, ba_dok 3 cycles later with ba_dout=32'hCAFE_BEEF -> ba_addr=22'h01234, ba_rnw=1, rq_dok=4'b0010 for one cycle, rq_dout=32'hCAFEBEEF.
- Single write: requester 3, rq_din=16'hA55A, rq_rnw=0 -> ba_din=16'hA55A, ba_rnw=0; rq_dok=4'b1000; rq_dout unchanged from the previous value.
- Round-robin: all four rq_req held, controller acks and completes each in 1 cycle -> grant order 0,1,2,3,0; no requester is served twice before the others.
- Coincident ack/dok: ba_ack and ba_dok both in the first ISSUE cycle -> WAIT skipped, rq_dok appears on the next edge, 3 cycles after the request.
- Watchdog with TOUT=8: controller never asserts ba_ack -> ba_req drops after 8 cycles, and rq_dok[gnt]=1 and rq_err[gnt]=1 in the same cycle.
- Reset mid-transfer: rst_n=0 during WAIT, then ba_dok pulses after release -> all outputs 0, state IDLE, no rq_dok; next grant starts from requester 0.
